// File: rtl/euclid_inv_arbiter.sv
// euclid_inv_arbiter: shares one extended-Euclidean modular-inverse engine
// between two requesters. Round-robin grant, operand latch, start/done engine
// sequencing, and per-requester valid/ready response return.
// Optional watchdog: define EUC_ARB_WATCHDOG_EN to abort a stalled engine
// after TIMEOUT_CYCLES wait cycles.
module euclid_inv_arbiter #(
  parameter int WIDTH          = 512,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_num0,
  input  logic [WIDTH-1:0] req_num1,
  input  logic [WIDTH-1:0] req_mod0,
  input  logic [WIDTH-1:0] req_mod1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_inv,
  output logic             rsp_err,
  output logic             rsp_timeout,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_num,
  output logic [WIDTH-1:0] eng_mod,
  output logic             eng_abort,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_inv,
  input  logic             eng_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q;     // requester served most recently
  logic             owner_q;    // requester owning the operation in flight
  logic [1:0]       grant;
  logic             accept;
  logic [WIDTH-1:0] sel_num, sel_mod;
  logic             timeout;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant = req_valid;
    if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign sel_num   = req_ready[1] ? req_num1 : req_num0;
  assign sel_mod   = req_ready[1] ? req_mod1 : req_mod0;

  assign eng_start = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

`ifdef EUC_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt_q;

  // The timeout fires on the TIMEOUT_CYCLES-th WAIT cycle; a coincident eng_done wins.
  assign timeout   = (state_q == WAIT) && !eng_done && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign eng_abort = timeout;

  // Watchdog counter: cleared while launching, counts engine-wait cycles.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                wd_cnt_q <= '0;
    else if (state_q == ISSUE) wd_cnt_q <= '0;
    else if (state_q == WAIT)  wd_cnt_q <= wd_cnt_q + CW'(1);
  end
`else
  // Without the watchdog the limit has no effect; keep it referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout   = 1'b0;
  assign eng_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; eng_done is only looked at while waiting on the engine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (sel_mod == '0) ? RESP : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (eng_done || timeout) state_d = RESP;
      RESP:  if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, result capture and round-robin pointer update.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      eng_num     <= '0;
      eng_mod     <= '0;
      rsp_inv     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          owner_q     <= req_ready[1];
          eng_num     <= sel_num;
          eng_mod     <= sel_mod;
          rsp_inv     <= '0;
          rsp_err     <= (sel_mod == '0);
          rsp_timeout <= 1'b0;
        end
        WAIT: if (eng_done) begin
          rsp_inv     <= eng_inv;
          rsp_err     <= eng_err;
          rsp_timeout <= 1'b0;
        end else if (timeout) begin
          rsp_inv     <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end
        RESP: if (rsp_ready[owner_q]) last_q <= owner_q;
        default: ;
      endcase
    end
  end

endmodule
